bus_arbiter: RTL

Two-master arbiter for the 8-bit system bus that feeds ROM (0x00-0x7f), RAM (0x80-0xfd) and GPIO (0xfe/0xff). It lets a second master, such as a loader or DMA engine, share the bus with the CPU. Masters use the existing level handshake: hold read or write plus address until ready. The block sits between the masters and the address decoder. It grants one master per transaction with round-robin fairness and aborts stalled transactions through a watchdog.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_watchdog.sv | 38 +++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus: widths, arbiter state
// encoding and the memory map seen behind the address decoder.
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    // ROM occupies 0x00..ROM_END, RAM sits between ROM and the two GPIO bytes.
    localparam logic [ADDR_W-1:0] ROM_END  = 8'h7f;
    localparam logic [ADDR_W-1:0] GPIO_IN  = 8'hfe;
    localparam logic [ADDR_W-1:0] GPIO_OUT = 8'hff;

    function automatic logic is_request(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall watchdog for the arbiter: counts BUSY cycles without a device ready
// and flags the cycle in which the current transaction has to be aborted.
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic expire
);

    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 1) ? CW_RAW : 1;
    localparam int LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIMIT_I);
    localparam logic [CW-1:0] SAT   = '1;

    logic [CW-1:0] count;

    // Saturating count so a disabled or very long watchdog can never wrap back
    // into the abort window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (busy && !ready && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (TIMEOUT != 0) && busy && !ready && (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the system bus address decoder,
// with pass-through handshake and watchdog abort of stalled transactions.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_data_out,
    output logic [DATA_W-1:0] m0_data_in,
    output logic              m0_ready,

    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_data_out,
    output logic [DATA_W-1:0] m1_data_in,
    output logic              m1_ready,

    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready,
    output logic              timeout
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last;
    logic       last_next;

    logic m0_req;
    logic m1_req;
    logic cur_req;
    logic busy;
    logic expire;
    logic abort;
    logic done;
    logic clear;

    assign m0_req  = is_request(m0_read, m0_write);
    assign m1_req  = is_request(m1_read, m1_write);
    assign busy    = (state != IDLE);
    assign cur_req = (state == BUSY1) ? m1_req : m0_req;

    // A master that already withdrew gets no forced ready and no timeout pulse.
    assign abort = expire && cur_req;
    assign done  = busy && (ready || abort);

    // Counter restarts on every fresh grant, including back-to-back handovers.
    assign clear = (state_next != IDLE) && (state_next != state);

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .busy  (busy),
        .ready (ready),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            last    <= last_next;
            timeout <= abort;
        end
    end

    // On completion the other master always gets the next slot if it waits,
    // which is what bounds the wait to one transaction of the other master.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || last)) begin
                    state_next = BUSY0;
                end else if (m1_req) begin
                    state_next = BUSY1;
                end
            end
            BUSY0: begin
                if (done) begin
                    state_next = m1_req ? BUSY1 : IDLE;
                end else if (!m0_req) begin
                    state_next = IDLE;
                end
            end
            BUSY1: begin
                if (done) begin
                    state_next = m0_req ? BUSY0 : IDLE;
                end else if (!m1_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if ((state_next == BUSY0) && (state != BUSY0)) begin
            last_next = 1'b0;
        end
        if ((state_next == BUSY1) && (state != BUSY1)) begin
            last_next = 1'b1;
        end
    end

    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        data_out   = '0;
        m0_data_in = '0;
        m0_ready   = 1'b0;
        m1_data_in = '0;
        m1_ready   = 1'b0;
        case (state)
            BUSY0: begin
                read       = m0_read && !abort;
                write      = m0_write && !abort;
                address    = m0_address;
                data_out   = m0_data_out;
                m0_ready   = ready || abort;
                m0_data_in = abort ? '0 : data_in;
            end
            BUSY1: begin
                read       = m1_read && !abort;
                write      = m1_write && !abort;
                address    = m1_address;
                data_out   = m1_data_out;
                m1_ready   = ready || abort;
                m1_data_in = abort ? '0 : data_in;
            end
            default: begin
            end
        endcase
    end

endmodule
